hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline. It is the counterpart of the forwarding unit: forwarding consumes results that are already available, and this block holds PC/IF-ID and injects ID-EX bubbles whenever forwarding cannot deliver a result in time.
- Covered cases: load-use on ALU operands, and branch/jr compare operands (compare forwarding exists only from EX-MEM ALU results).
- Also issues the IF-ID flush for taken branches/jumps and freezes the whole pipeline while data memory is busy.

Parameters:
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- IFID_rs  in  5  rs of the instruction in ID
- IFID_rt  in  5  rt of the instruction in ID
- IFID_usert  in  1  ID instruction reads rt as a register operand
- IFID_pcsrc  in  3  001 = branch, 011 = jr, 010 = j/jal, others = sequential
- branch_taken  in  1  ID compare result; valid when IFID_pcsrc == 001
- IDEX_memrd  in  1  EX instruction is a load
- IDEX_regwr  in  1  EX instruction writes a register
- IDEX_wraddr  in  5  EX destination register
- EXMEM_memrd  in  1  MEM instruction is a load
- EXMEM_wraddr  in  5  MEM destination register
- mem_busy  in  1  data memory wait request
- pc_write  out  1  1 = PC updates
- ifid_write  out  1  1 = IF-ID register loads
- idex_bubble  out  1  1 = ID-EX loads a NOP (control bits cleared)
- ifid_flush  out  1  1 = IF-ID loads a NOP
- freeze  out  1  1 = all pipeline registers hold
- stall_count  out  CNT_W  number of cycles with idex_bubble = 1

Behaviour:
- Hazard matching:
  - match(x) = (x != 0) && (x == IFID_rs || (IFID_usert && x == IFID_rt)).
  - For jr, only rs is compared.
  - is_br = IFID_pcsrc is 001 or 011.
- Stall need n, evaluated only in state IDLE:
  - 2 if is_br && IDEX_memrd && match(IDEX_wraddr).
  - Else 1 if IDEX_memrd && match(IDEX_wraddr) (load-use).
  - Else 1 if is_br && IDEX_regwr && match(IDEX_wraddr).
  - Else 1 if is_br && EXMEM_memrd && match(EXMEM_wraddr).
  - Else 0.
- FSM states: IDLE, STALL, FREEZE. A 2-bit register `remain` holds outstanding stall cycles.
  - IDLE, mem_busy = 1: freeze = 1 and every other control deasserted. Go to FREEZE; `remain` keeps its value.
  - IDLE, n > 0: pc_write = 0, ifid_write = 0, idex_bubble = 1 in this same cycle (Mealy). Load remain = n-1. Go to STALL if n-1 > 0, else stay in IDLE.
  - IDLE, n = 0: pc_write = 1, ifid_write = 1.
    - ifid_flush = 1 if (IFID_pcsrc == 001 && branch_taken) or IFID_pcsrc is 011 or 010.
  - STALL: stall outputs asserted without re-evaluating n. Decrement remain; go to IDLE when remain reaches 0. mem_busy in STALL takes priority: go to FREEZE with remain preserved.
  - FREEZE: freeze = 1, pc_write = 0, ifid_write = 0, idex_bubble = 0, ifid_flush = 0. When mem_busy drops, go to STALL if remain > 0, else IDLE. No decrement while frozen.
- Priority: freeze > stall > flush. A branch being stalled never flushes until its stall completes and n re-evaluates to 0.
- stall_count increments on every cycle with idex_bubble = 1. It saturates at all-ones and does not wrap.
- Reset, asynchronous, including mid-stall or mid-freeze:
  - State IDLE, remain 0, stall_count 0.
  - While reset is high, outputs are forced to pc_write 0, ifid_write 0, idex_bubble 1, ifid_flush 1, freeze 0.
  - The first post-reset cycle evaluates normally.
- No latency on outputs: all stall/flush outputs are combinational from state plus inputs. Only state, remain and stall_count are registered.

Decomposition:
- Shared package holds:
  - pcsrc encodings (PCSRC_SEQ 000, PCSRC_BR 001, PCSRC_J 010, PCSRC_JR 011).
  - FSM state typedef.
  - REG_ZERO constant.
- One natural sub-module: hazard_detect, combinational, computing n and the flush request. The FSM and counter stay in hazard_ctrl.

Test Plan:
- Load-use: lw $8 in EX (IDEX_memrd = 1, IDEX_wraddr = 8); add in ID with rs = 8. Required: one cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1, then a normal cycle; stall_count = 1.
- Branch after load: IDEX lw $9; beq in ID with rt = 9, IFID_usert = 1. Required: exactly 2 bubble cycles, then branch_taken = 1 gives ifid_flush = 1 on the third cycle; stall_count = 2.
- Branch after ALU op: IDEX_regwr = 1, IDEX_wraddr = 5; jr $5. Required: 1 bubble cycle, then ifid_flush = 1.
- Register $0 and non-matches: IDEX lw $0 with rs = 0, and IDEX lw $3 with rt = 3 but IFID_usert = 0. Required: no stall in either case.
- Freeze mid-stall: during the first bubble cycle of a 2-cycle stall, assert mem_busy for 3 cycles. Required: freeze = 1 for 3 cycles, then exactly 1 more bubble cycle; stall_count = 2.
- Reset mid-stall, then saturation: assert reset in STALL. Required: outputs immediately show the forced reset values; after release, state is IDLE and stall_count is 0. With CNT_W = 2, 5 consecutive stalls leave stall_count = 3.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl_pkg : shared encodings for the pipeline hazard control |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
package hazard_ctrl_pkg;

  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_BR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_detect : stall-need and flush-request decode for the ID stage |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_usert,
  input  logic [2:0] ifid_pcsrc,
  input  logic       branch_taken,
  input  logic       idex_memrd,
  input  logic       idex_regwr,
  input  logic [4:0] idex_wraddr,
  input  logic       exmem_memrd,
  input  logic [4:0] exmem_wraddr,
  output logic [1:0] need,
  output logic       flush_req
);

  logic is_br;
  logic use_rt;
  logic idex_hit;
  logic exmem_hit;

  assign is_br  = (ifid_pcsrc == PCSRC_BR) || (ifid_pcsrc == PCSRC_JR);
  // jr only reads rs, whatever the rt field happens to hold
  assign use_rt = ifid_usert && (ifid_pcsrc != PCSRC_JR);

  assign idex_hit  = (idex_wraddr != REG_ZERO) &&
                     ((idex_wraddr == ifid_rs) || (use_rt && (idex_wraddr == ifid_rt)));
  assign exmem_hit = (exmem_wraddr != REG_ZERO) &&
                     ((exmem_wraddr == ifid_rs) || (use_rt && (exmem_wraddr == ifid_rt)));

  always_comb begin
    need = 2'd0;
    if (is_br && idex_memrd && idex_hit)
      need = 2'd2;
    else if (idex_memrd && idex_hit)
      need = 2'd1;
    else if (is_br && idex_regwr && idex_hit)
      need = 2'd1;
    else if (is_br && exmem_memrd && exmem_hit)
      need = 2'd1;
  end

  assign flush_req = ((ifid_pcsrc == PCSRC_BR) && branch_taken) ||
                     (ifid_pcsrc == PCSRC_JR) || (ifid_pcsrc == PCSRC_J);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl : stall / flush / freeze controller, 5-stage pipeline  |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_rs,
  input  logic [4:0]       IFID_rt,
  input  logic             IFID_usert,
  input  logic [2:0]       IFID_pcsrc,
  input  logic             branch_taken,
  input  logic             IDEX_memrd,
  input  logic             IDEX_regwr,
  input  logic [4:0]       IDEX_wraddr,
  input  logic             EXMEM_memrd,
  input  logic [4:0]       EXMEM_wraddr,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nx;
  state_t     eff_state;
  logic [1:0] remain;
  logic [1:0] remain_nx;
  logic [1:0] need;
  logic       flush_req;

  hazard_detect u_detect (
    .ifid_rs      (IFID_rs),
    .ifid_rt      (IFID_rt),
    .ifid_usert   (IFID_usert),
    .ifid_pcsrc   (IFID_pcsrc),
    .branch_taken (branch_taken),
    .idex_memrd   (IDEX_memrd),
    .idex_regwr   (IDEX_regwr),
    .idex_wraddr  (IDEX_wraddr),
    .exmem_memrd  (EXMEM_memrd),
    .exmem_wraddr (EXMEM_wraddr),
    .need         (need),
    .flush_req    (flush_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      remain <= 2'd0;
    end else begin
      state  <= state_nx;
      remain <= remain_nx;
    end
  end

  // Once memory releases, the FREEZE cycle already acts as the resumed
  // state so no dead cycle is inserted between freeze and the pipeline.
  always_comb begin
    eff_state = state;
    if ((state == ST_FREEZE) && !mem_busy)
      eff_state = (remain != 2'd0) ? ST_STALL : ST_IDLE;
  end

  always_comb begin
    state_nx  = state;
    remain_nx = remain;
    if (mem_busy) begin
      state_nx = ST_FREEZE;
    end else begin
      case (eff_state)
        ST_IDLE: begin
          state_nx = ST_IDLE;
          if (need != 2'd0) begin
            remain_nx = need - 2'd1;
            state_nx  = (need > 2'd1) ? ST_STALL : ST_IDLE;
          end
        end
        ST_STALL: begin
          remain_nx = (remain != 2'd0) ? remain - 2'd1 : 2'd0;
          state_nx  = (remain > 2'd1) ? ST_STALL : ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    freeze      = 1'b0;
    if (reset) begin
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (mem_busy) begin
      freeze = 1'b1;
    end else begin
      case (eff_state)
        ST_IDLE: begin
          if (need != 2'd0) begin
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = flush_req;
          end
        end
        ST_STALL: idex_bubble = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (idex_bubble && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_ONE;
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hazard_ctrl : directed self-checking bench for hazard_ctrl      |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module tb_hazard_ctrl;

  // {pc_write, ifid_write, idex_bubble, ifid_flush, freeze}
  localparam logic [4:0] NORMAL = 5'b11000;
  localparam logic [4:0] NFLUSH = 5'b11010;
  localparam logic [4:0] BUB    = 5'b00100;
  localparam logic [4:0] FRZ    = 5'b00001;
  localparam logic [4:0] RST    = 5'b00110;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IFID_rs, IFID_rt, IDEX_wraddr, EXMEM_wraddr;
  logic        IFID_usert, branch_taken, IDEX_memrd, IDEX_regwr, EXMEM_memrd, mem_busy;
  logic [2:0]  IFID_pcsrc;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, freeze;
  logic [31:0] stall_count;
  logic        s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush, s_freeze;
  logic [1:0]  sat_count;
  logic [4:0]  ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_write, ifid_write, idex_bubble, ifid_flush, freeze};

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
    .IFID_usert(IFID_usert), .IFID_pcsrc(IFID_pcsrc), .branch_taken(branch_taken),
    .IDEX_memrd(IDEX_memrd), .IDEX_regwr(IDEX_regwr), .IDEX_wraddr(IDEX_wraddr),
    .EXMEM_memrd(EXMEM_memrd), .EXMEM_wraddr(EXMEM_wraddr), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .freeze(freeze), .stall_count(stall_count)
  );

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
    .IFID_usert(IFID_usert), .IFID_pcsrc(IFID_pcsrc), .branch_taken(branch_taken),
    .IDEX_memrd(IDEX_memrd), .IDEX_regwr(IDEX_regwr), .IDEX_wraddr(IDEX_wraddr),
    .EXMEM_memrd(EXMEM_memrd), .EXMEM_wraddr(EXMEM_wraddr), .mem_busy(mem_busy),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_bubble(s_idex_bubble),
    .ifid_flush(s_ifid_flush), .freeze(s_freeze), .stall_count(sat_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    IFID_rs = 5'd0; IFID_rt = 5'd0; IFID_usert = 1'b0; IFID_pcsrc = 3'b000;
    branch_taken = 1'b0; IDEX_memrd = 1'b0; IDEX_regwr = 1'b0; IDEX_wraddr = 5'd0;
    EXMEM_memrd = 1'b0; EXMEM_wraddr = 5'd0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // lw $9 in EX, beq using $9 as rt in ID: two bubbles needed
  task automatic set_branch_after_load();
    clear_inputs();
    IDEX_memrd = 1'b1; IDEX_regwr = 1'b1; IDEX_wraddr = 5'd9;
    IFID_pcsrc = 3'b001; IFID_rs = 5'd4; IFID_rt = 5'd9; IFID_usert = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    checks++; if (ctl !== RST) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, RST); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", stall_count); end
    tick();
    reset = 1'b0;
    settle();
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL reset_first_cycle: got %b want %b", ctl, NORMAL); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_memrd = 1'b1; IDEX_regwr = 1'b1; IDEX_wraddr = 5'd8; IFID_rs = 5'd8; IFID_rt = 5'd2;
    settle();
    checks++; if (ctl !== BUB) begin errors++; $display("FAIL load_use_bubble: got %b want %b", ctl, BUB); end
    tick();
    clear_inputs();
    EXMEM_memrd = 1'b1; EXMEM_wraddr = 5'd8; IFID_rs = 5'd8; IFID_rt = 5'd2;
    settle();
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL load_use_resume: got %b want %b", ctl, NORMAL); end
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL load_use_count: got %0d want 1", stall_count); end
    tick();
  endtask

  task automatic test_branch_after_load();
    do_reset();
    set_branch_after_load();
    settle();
    checks++; if (ctl !== BUB) begin errors++; $display("FAIL br_load_c1: got %b want %b", ctl, BUB); end
    tick();
    IDEX_memrd = 1'b0; IDEX_regwr = 1'b0; IDEX_wraddr = 5'd0;
    EXMEM_memrd = 1'b1; EXMEM_wraddr = 5'd9; branch_taken = 1'b1;
    settle();
    checks++; if (ctl !== BUB) begin errors++; $display("FAIL br_load_c2: got %b want %b", ctl, BUB); end
    tick();
    EXMEM_memrd = 1'b0; EXMEM_wraddr = 5'd0;
    settle();
    checks++; if (ctl !== NFLUSH) begin errors++; $display("FAIL br_load_flush: got %b want %b", ctl, NFLUSH); end
    checks++; if (stall_count !== 32'd2) begin errors++; $display("FAIL br_load_count: got %0d want 2", stall_count); end
    tick();
  endtask

  task automatic test_branch_after_alu();
    do_reset();
    IDEX_regwr = 1'b1; IDEX_wraddr = 5'd5; IFID_pcsrc = 3'b011; IFID_rs = 5'd5; IFID_rt = 5'd7;
    settle();
    checks++; if (ctl !== BUB) begin errors++; $display("FAIL jr_alu_bubble: got %b want %b", ctl, BUB); end
    tick();
    IDEX_regwr = 1'b0; IDEX_wraddr = 5'd0; EXMEM_wraddr = 5'd5;
    settle();
    checks++; if (ctl !== NFLUSH) begin errors++; $display("FAIL jr_alu_flush: got %b want %b", ctl, NFLUSH); end
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL jr_alu_count: got %0d want 1", stall_count); end
    tick();
    // jr ignores rt even when usert is set
    clear_inputs();
    IDEX_memrd = 1'b1; IDEX_wraddr = 5'd7; IFID_pcsrc = 3'b011; IFID_rs = 5'd2; IFID_rt = 5'd7; IFID_usert = 1'b1;
    settle();
    checks++; if (ctl !== NFLUSH) begin errors++; $display("FAIL jr_rt_ignored: got %b want %b", ctl, NFLUSH); end
    tick();
  endtask

  task automatic test_no_match();
    do_reset();
    IDEX_memrd = 1'b1; IDEX_wraddr = 5'd0; IFID_rs = 5'd0;
    settle();
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL zero_reg: got %b want %b", ctl, NORMAL); end
    tick();
    clear_inputs();
    IDEX_memrd = 1'b1; IDEX_wraddr = 5'd3; IFID_rs = 5'd1; IFID_rt = 5'd3; IFID_usert = 1'b0;
    settle();
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL rt_unused: got %b want %b", ctl, NORMAL); end
    tick();
    clear_inputs();
    IFID_pcsrc = 3'b010;
    settle();
    checks++; if (ctl !== NFLUSH) begin errors++; $display("FAIL jump_flush: got %b want %b", ctl, NFLUSH); end
    tick();
    IFID_pcsrc = 3'b001; branch_taken = 1'b0;
    settle();
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL br_not_taken: got %b want %b", ctl, NORMAL); end
    tick();
    EXMEM_memrd = 1'b1; EXMEM_wraddr = 5'd6; IFID_rs = 5'd6; branch_taken = 1'b1;
    settle();
    checks++; if (ctl !== BUB) begin errors++; $display("FAIL br_exmem_load: got %b want %b", ctl, BUB); end
    tick();
    clear_inputs();
    settle();
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL no_match_count: got %0d want 1", stall_count); end
    tick();
  endtask

  task automatic test_freeze_mid_stall();
    do_reset();
    set_branch_after_load();
    settle();
    checks++; if (ctl !== BUB) begin errors++; $display("FAIL frz_c1: got %b want %b", ctl, BUB); end
    tick();
    IDEX_memrd = 1'b0; IDEX_regwr = 1'b0; IDEX_wraddr = 5'd0;
    EXMEM_memrd = 1'b1; EXMEM_wraddr = 5'd9; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (ctl !== FRZ) begin errors++; $display("FAIL frz_hold%0d: got %b want %b", i, ctl, FRZ); end
      tick();
    end
    mem_busy = 1'b0;
    settle();
    checks++; if (ctl !== BUB) begin errors++; $display("FAIL frz_resume_bubble: got %b want %b", ctl, BUB); end
    tick();
    EXMEM_memrd = 1'b0; EXMEM_wraddr = 5'd0; branch_taken = 1'b1;
    settle();
    checks++; if (ctl !== NFLUSH) begin errors++; $display("FAIL frz_flush: got %b want %b", ctl, NFLUSH); end
    checks++; if (stall_count !== 32'd2) begin errors++; $display("FAIL frz_count: got %0d want 2", stall_count); end
    tick();
  endtask

  task automatic test_freeze_idle();
    do_reset();
    IDEX_memrd = 1'b1; IDEX_wraddr = 5'd8; IFID_rs = 5'd8; mem_busy = 1'b1;
    settle();
    checks++; if (ctl !== FRZ) begin errors++; $display("FAIL frz_idle: got %b want %b", ctl, FRZ); end
    tick();
    mem_busy = 1'b0;
    settle();
    checks++; if (ctl !== BUB) begin errors++; $display("FAIL frz_idle_release: got %b want %b", ctl, BUB); end
    tick();
    clear_inputs();
    settle();
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL frz_idle_after: got %b want %b", ctl, NORMAL); end
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL frz_idle_count: got %0d want 1", stall_count); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_branch_after_load();
    settle();
    checks++; if (ctl !== BUB) begin errors++; $display("FAIL rst_mid_c1: got %b want %b", ctl, BUB); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (ctl !== RST) begin errors++; $display("FAIL rst_mid_forced: got %b want %b", ctl, RST); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", stall_count); end
    reset = 1'b0;
    clear_inputs();
    #2;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL rst_mid_idle: got %b want %b", ctl, NORMAL); end
    tick();
    settle();
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL rst_mid_count_after: got %0d want 0", stall_count); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    IDEX_memrd = 1'b1; IDEX_wraddr = 5'd8; IFID_rs = 5'd8;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++; if (ctl !== BUB) begin errors++; $display("FAIL sat_bubble%0d: got %b want %b", i, ctl, BUB); end
      tick();
    end
    clear_inputs();
    settle();
    checks++; if (sat_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", sat_count); end
    checks++; if (stall_count !== 32'd5) begin errors++; $display("FAIL wide_count: got %0d want 5", stall_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_branch_after_alu();
    test_no_match();
    test_freeze_mid_stall();
    test_freeze_idle();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
